// File: rtl/image_streamer.sv
// Raster-order frame reader: walks a WxH image from a base address, issues one
// memory read per enabled cycle and streams the returned pixels with coordinates.
module image_streamer #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int ADDR_WIDTH   = 20,
    parameter int LINE_GAP     = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  en_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [15:0]           col_o,
    output logic [15:0]           row_o,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    if (longint'(IMAGE_WIDTH) * longint'(IMAGE_HEIGHT) > (longint'(1) << ADDR_WIDTH)) begin : g_size_check
        $error("image_streamer: IMAGE_WIDTH*IMAGE_HEIGHT exceeds the address space");
    end

    localparam logic [15:0] COL_LAST = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMAGE_HEIGHT - 1);
    localparam logic [7:0]  GAP_LOAD = (LINE_GAP > 0) ? 8'(LINE_GAP - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DRAIN} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] index;
    logic [15:0]           col;
    logic [15:0]           row;
    logic [7:0]            wait_cnt;
    logic                  issue;
    logic                  last_col;
    logic                  last_row;

    logic                  vld_p1;
    logic                  last_p1;
    logic [15:0]           col_p1;
    logic [15:0]           row_p1;

    assign last_col  = (col == COL_LAST);
    assign last_row  = (row == ROW_LAST);
    assign rd_en_o   = issue;
    assign rd_addr_o = base + index;
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_next = ACTIVE;
            end
            ACTIVE: begin
                if (en_i) begin
                    issue = 1'b1;
                    if (last_col) begin
                        if (last_row)          state_next = DRAIN;
                        else if (LINE_GAP > 0) state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (wait_cnt == 8'd0) state_next = ACTIVE;
            end
            DRAIN: begin
                if (wait_cnt == 8'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // wait_cnt is shared: GAP length after a row end, pipeline drain after the frame end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base     <= '0;
            index    <= '0;
            col      <= '0;
            row      <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                base  <= base_addr_i;
                index <= '0;
                col   <= '0;
                row   <= '0;
            end
            if (issue) begin
                index <= index + ADDR_WIDTH'(1);
                if (last_col) begin
                    col      <= '0;
                    wait_cnt <= last_row ? 8'd1 : GAP_LOAD;
                    if (!last_row) row <= row + 16'd1;
                end else begin
                    col <= col + 16'd1;
                end
            end
            if ((state == GAP || state == DRAIN) && wait_cnt != 8'd0) begin
                wait_cnt <= wait_cnt - 8'd1;
            end
        end
    end

    // Stage p1: coordinates travel alongside the outstanding memory read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= issue;
            last_p1 <= issue & last_col & last_row;
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue) begin
            col_p1 <= col;
            row_p1 <= row;
        end
    end

    // Stage p2: output register capturing the returned memory word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            data_o  <= '0;
            col_o   <= '0;
            row_o   <= '0;
        end else begin
            valid_o <= vld_p1;
            done_o  <= last_p1;
            if (vld_p1) begin
                data_o <= rd_data_i;
                col_o  <= col_p1;
                row_o  <= row_p1;
            end
        end
    end

endmodule

// File: tb/tb_image_streamer.sv
// Bench for image_streamer: two instances (no line gap / 2-cycle line gap) sharing
// stimulus, a 1-cycle memory model each, and a queue-based scoreboard per instance.
module tb_image_streamer;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 20;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] c;
        logic [15:0] r;
        logic        last;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [AW-1:0] base_addr;
    logic [1:0]    start, rd_en, valid, busy, done;
    logic [AW-1:0] rd_addr [2];
    logic [DW-1:0] rd_data [2];
    logic [DW-1:0] data    [2];
    logic [15:0]   col     [2];
    logic [15:0]   row     [2];

    pix_t q0[$], q1[$];
    int   vt0[$], vt1[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        image_streamer #(
            .DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
            .ADDR_WIDTH(AW), .LINE_GAP(2 * g)
        ) dut (
            .clk_i(clk), .rst_i(rst), .start_i(start[g]), .base_addr_i(base_addr),
            .en_i(en), .rd_en_o(rd_en[g]), .rd_addr_o(rd_addr[g]), .rd_data_i(rd_data[g]),
            .data_o(data[g]), .col_o(col[g]), .row_o(row[g]), .valid_o(valid[g]),
            .busy_o(busy[g]), .done_o(done[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents depend on the upper address bits so address wrap is visible in the data
    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        return a[15:0] ^ {a[19:16], 12'h000};
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) if (rd_en[g]) rd_data[g] <= mem_word(rd_addr[g]);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    // Reference: a frame is the W*H raster of words at (base + r*W + c) mod 2^AW
    task automatic push_frame(input int k, input logic [AW-1:0] b);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                longint a;
                pix_t   p;
                a = (longint'(b) + longint'(r * W + c)) % (longint'(1) << AW);
                p = '{d: mem_word(AW'(a)), c: 16'(c), r: 16'(r), last: (r == H - 1 && c == W - 1)};
                if (k == 0) q0.push_back(p); else q1.push_back(p);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (valid[g]) begin
                if (qsize(g) == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pixel[%0d]: got col %0d row %0d, required no output", g, col[g], row[g]);
                end else begin
                    pix_t e;
                    e = (g == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("data[%0d]", g), 64'(data[g]), 64'(e.d));
                    chk($sformatf("col[%0d]", g),  64'(col[g]),  64'(e.c));
                    chk($sformatf("row[%0d]", g),  64'(row[g]),  64'(e.r));
                    chk($sformatf("done[%0d]", g), 64'(done[g]), 64'(e.last));
                end
                if (g == 0) vt0.push_back(cyc); else vt1.push_back(cyc);
            end else if (done[g]) begin
                chk($sformatf("done_without_valid[%0d]", g), 64'(done[g]), 64'd0);
            end
        end
    end

    task automatic run_frame(input int k, input logic [AW-1:0] b, output int s);
        base_addr = b;
        start[k]  = 1'b1;
        s         = cyc;
        push_frame(k, b);
        @(negedge clk);
        start[k]  = 1'b0;
    endtask

    task automatic wait_idle(input int k, input bit rand_en);
        int n = 0;
        while ((busy[k] || qsize(k) != 0) && n < 400) begin
            if (rand_en) en = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        en = 1'b1;
        chk($sformatf("idle_timeout[%0d]", k), 64'(n < 400), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, n;
        rst = 1'b1; en = 1'b1; start = '0; base_addr = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_ctrl[%0d]", g),  64'({rd_en[g], valid[g], busy[g], done[g]}), 64'd0);
            chk($sformatf("rst_addr[%0d]", g),  64'(rd_addr[g]), 64'd0);
            chk($sformatf("rst_coord[%0d]", g), 64'({col[g], row[g]}), 64'd0);
            chk($sformatf("rst_data[%0d]", g),  64'(data[g]), 64'd0);
        end

        // Basic frame, started on the first cycle after reset release
        rst = 1'b0;
        vt0.delete();
        run_frame(0, 20'h00100, s);
        wait_idle(0, 1'b0);
        chk("s1_count", 64'(vt0.size()), 64'd12);
        if (vt0.size() == 12) begin
            chk("s1_first", 64'(vt0[0]), 64'(s + 3));
            chk("s1_last",  64'(vt0[11]), 64'(s + 14));
        end

        // Line gap of 2 after rows 0 and 1 only
        vt1.delete();
        run_frame(1, 20'h00100, s);
        wait_idle(1, 1'b0);
        chk("s2_count", 64'(vt1.size()), 64'd12);
        if (vt1.size() == 12) begin
            chk("s2_span", 64'(vt1[11] - vt1[0] + 1), 64'd16);
            for (int i = 1; i < 12; i++)
                chk($sformatf("s2_step%0d", i), 64'(vt1[i] - vt1[i-1]), 64'((i % 4 == 0) ? 3 : 1));
        end

        // Enable low for 3 cycles right after (1,1) is issued
        vt0.delete();
        run_frame(0, 20'h00400, s);
        while (cyc < s + 7) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_idle(0, 1'b0);
        chk("s3_count", 64'(vt0.size()), 64'd12);
        if (vt0.size() == 12)
            for (int i = 1; i < 12; i++)
                chk($sformatf("s3_step%0d", i), 64'(vt0[i] - vt0[i-1]), 64'((i == 6) ? 4 : 1));

        // start during ACTIVE with another base is ignored
        vt0.delete();
        run_frame(0, 20'h00200, s);
        while (cyc < s + 4) @(negedge clk);
        base_addr = 20'h003F0;
        start[0]  = 1'b1;
        @(negedge clk);
        start[0]  = 1'b0;
        wait_idle(0, 1'b0);
        chk("s4_count", 64'(vt0.size()), 64'd12);

        // Reset mid-frame after 5 pixels issued
        vt0.delete();
        run_frame(0, AW'($urandom), s);
        while (cyc < s + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        q0.delete();
        chk("s5_valid", 64'(valid[0]), 64'd0);
        chk("s5_busy",  64'(busy[0]),  64'd0);
        chk("s5_done",  64'(done[0]),  64'd0);
        chk("s5_count", 64'(vt0.size()), 64'd4);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run_frame(0, AW'($urandom), s);
        wait_idle(0, 1'b0);

        // start held high: back-to-back frames with one idle cycle between
        vt0.delete();
        base_addr = AW'($urandom);
        start[0]  = 1'b1;
        s         = cyc;
        push_frame(0, base_addr);
        push_frame(0, base_addr);
        n = 0;
        do begin @(negedge clk); n++; end while (!done[0] && n < 100);
        chk("s6_done_seen", 64'(done[0]), 64'd1);
        d = cyc;
        @(negedge clk);
        chk("s6_bubble_busy", 64'(busy[0]), 64'd0);
        @(negedge clk);
        start[0] = 1'b0;
        chk("s6_restart_busy", 64'(busy[0]), 64'd1);
        wait_idle(0, 1'b0);
        chk("s6_count", 64'(vt0.size()), 64'd24);
        if (vt0.size() == 24) begin
            chk("s6_done_time", 64'(vt0[11]), 64'(d));
            chk("s6_second_start", 64'(vt0[12] - d), 64'd4);
        end

        // Randomised enable, including a base that wraps past the top of the address space
        for (int k = 0; k < 2; k++) begin
            run_frame(k, 20'hFFFF8, s);
            wait_idle(k, 1'b1);
            run_frame(k, AW'($urandom), s);
            wait_idle(k, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/image_streamer.md
IMAGE_STREAMER -- requirements
Module: image_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the pixel width in bits.
REQ-002 The block SHALL have parameter IMAGE_WIDTH, default 640, giving the pixels per row (2..65535).
REQ-003 The block SHALL have parameter IMAGE_HEIGHT, default 480, giving the rows per frame (1..65535).
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 20, giving the memory address width; IMAGE_WIDTH*IMAGE_HEIGHT SHALL be at most 2^ADDR_WIDTH (elaboration error otherwise).
REQ-005 The block SHALL have parameter LINE_GAP, default 0, giving the idle cycles inserted after each non-final row (0..255).
REQ-006 The block SHALL have ports clk_i (in, 1), the single clock, and rst_i (in, 1), a synchronous active-high reset.
REQ-007 The block SHALL have port start_i (in, 1), which starts one frame when the block is idle.
REQ-008 The block SHALL have port base_addr_i (in, ADDR_WIDTH), the frame base address, sampled when start is accepted.
REQ-009 The block SHALL have port en_i (in, 1), a pixel-issue enable; low stalls issue.
REQ-010 The block SHALL have ports rd_en_o (out, 1) and rd_addr_o (out, ADDR_WIDTH), the memory read request.
REQ-011 The block SHALL have port rd_data_i (in, DATA_WIDTH), memory read data, valid exactly 1 cycle after rd_en_o.
REQ-012 The block SHALL have ports data_o (out, DATA_WIDTH), col_o (out, 16), row_o (out, 16) and valid_o (out, 1), the raster pixel stream (push model, no backpressure).
REQ-013 The block SHALL have ports busy_o (out, 1), high from start acceptance until the last pixel leaves, and done_o (out, 1), a 1-cycle pulse with the last pixel's valid_o.

Function
REQ-014 The FSM SHALL have states IDLE, ACTIVE, GAP and DRAIN.
REQ-015 In IDLE with start_i=1, the next state SHALL be ACTIVE; the block SHALL latch base_addr_i and clear the col, row and index counters.
REQ-016 In ACTIVE with en_i=1, the block SHALL issue rd_en_o=1 and rd_addr_o=base+index, then increment index and advance col (and row on wrap) in the same cycle.
REQ-017 In ACTIVE with en_i=0, rd_en_o SHALL be 0, all counters SHALL hold, and the state SHALL be unchanged.
REQ-018 Issue of col=IMAGE_WIDTH-1 on a non-final row SHALL set col to 0 and increment row; the next state SHALL be GAP if LINE_GAP>0, else ACTIVE.
REQ-019 GAP SHALL last exactly LINE_GAP cycles regardless of en_i, with rd_en_o=0, then return to ACTIVE.
REQ-020 Issue of the final pixel (col=W-1, row=H-1) SHALL move the FSM to DRAIN.
REQ-021 DRAIN SHALL wait until the pipeline is empty (2 cycles), then go to IDLE.
REQ-022 Each issue SHALL produce valid_o=1 exactly 2 cycles later (issue, memory, output register); data_o SHALL be rd_data_i registered, and col_o/row_o SHALL be the issue coordinates delayed 2 cycles.
REQ-023 When valid_o=0, data_o, col_o and row_o SHALL hold their last values.
REQ-024 Pixels SHALL leave in strict raster order: col 0..W-1 within row 0..H-1.
REQ-025 The first valid pixel of a frame SHALL be col_o=0 and row_o=0, so it is usable as the downstream start-of-frame marker.
REQ-026 start_i SHALL be ignored in all states except IDLE.
REQ-027 busy_o SHALL fall in the cycle after done_o; start_i asserted in that cycle SHALL be accepted, giving back-to-back frames with a 1-cycle bubble.
REQ-028 rd_addr_o arithmetic SHALL be modulo 2^ADDR_WIDTH.
REQ-029 When IMAGE_HEIGHT=1, no GAP SHALL be inserted.

Reset
REQ-030 While rst_i=1 at a clock edge, the next state SHALL be IDLE, and rd_en_o, valid_o, busy_o, done_o, col_o, row_o, data_o, rd_addr_o and all counters SHALL be 0.
REQ-031 Reset mid-frame SHALL drop in-flight pixels: valid_o=0 from the first reset cycle onward, with no done_o.
REQ-032 After reset release, the block SHALL accept start_i on the first cycle.

Verification
REQ-033 The bench SHALL cover: W=4, H=3, LINE_GAP=0, base=0x100, en_i=1, memory returns addr -> valid_o for 12 consecutive cycles starting 3 cycles after start_i; data 0x100..0x10B; col/row raster; done_o with (3,2).
REQ-034 The bench SHALL cover: same setup with LINE_GAP=2 -> exactly 2 valid_o=0 cycles after (3,0) and after (3,1), none after (3,2); 16-cycle active span.
REQ-035 The bench SHALL cover: en_i low for 3 cycles after issue of (1,1) -> 3 valid_o=0 bubbles after (1,1); next output (2,1), no skipped or duplicate pixels.
REQ-036 The bench SHALL cover: start_i pulsed during ACTIVE with a different base -> ignored; the frame completes from the original base.
REQ-037 The bench SHALL cover: rst_i for 1 cycle after 5 pixels issued -> valid_o=0 and busy_o=0 next cycle, no done_o; a new start yields (0,0) first.
REQ-038 The bench SHALL cover: start_i held high continuously -> back-to-back frames, each beginning at (0,0), with a 1-cycle bubble between done_o and the next issue.
